bf16_addsub_sched: RTL and testbench

Two-requester scheduler that time-shares one combinational BF16 `addsub` datapath instance.
- Arbitrates between two operand streams with valid/ready handshakes.
- Registers the operands, captures the `addsub` result, and returns it on a single result channel tagged with the requester ID.
- Sits between the BF16 vector/accumulate front-ends and the shared adder.

---
 rtl/bf16_addsub_sched.sv | 219 +++++++++++++++++++++
 tb/tb_bf16_addsub_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf16_addsub_sched.sv
`default_nettype none
// ============================================================================
// Module      : bf16_addsub / bf16_addsub_sched
// Description : Two-requester scheduler time-sharing one combinational BF16
//               add/subtract datapath. Operands are registered on handshake,
//               the datapath result is captured one cycle later and returned
//               on a single result channel tagged with the requester ID.
// Ports (bf16_addsub_sched):
//   clk, rst_n                   clock, async active-low reset
//   reqN_valid/ready             requester N handshake (N = 0,1)
//   reqN_a, reqN_b, reqN_op      requester N operands, op 0=ADD 1=SUB (a-b)
//   res_valid/res_ready          result handshake
//   res_data, res_id             BF16 result and issuing requester
//   busy                         high whenever the FSM is not idle
// Revision    : 1.0 - initial release
// ============================================================================

// Combinational BF16 add/sub: round-to-nearest-even, subnormals flushed to
// zero, NaN results are the canonical quiet NaN.
module bf16_addsub (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        op_i,
  output logic [15:0] res_o
);
  localparam logic [15:0] C_QNAN = 16'h7FC0;

  logic        w_sa, w_sb, w_sx, w_sy, w_swap, w_eff_sub;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_rnd;
  logic [7:0]  w_ea, w_eb, w_ex, w_ey, w_d;
  logic [7:0]  w_ma, w_mb, w_mx, w_my;
  logic [33:0] w_yfull;
  logic [18:0] w_xa, w_ya, w_sum;
  logic [17:0] w_norm;
  logic [4:0]  w_lz;
  logic [9:0]  w_exp, w_exp_r;
  logic [8:0]  w_mr;
  logic [6:0]  w_frac;

  always_comb begin
    w_sa    = a_i[15];
    w_sb    = b_i[15] ^ op_i;   // subtraction is addition of negated b
    w_ea    = a_i[14:7];
    w_eb    = b_i[14:7];
    w_ma    = (w_ea == 8'd0) ? 8'd0 : {1'b1, a_i[6:0]};
    w_mb    = (w_eb == 8'd0) ? 8'd0 : {1'b1, b_i[6:0]};
    w_a_nan = (w_ea == 8'hFF) && (a_i[6:0] != 7'd0);
    w_b_nan = (w_eb == 8'hFF) && (b_i[6:0] != 7'd0);
    w_a_inf = (w_ea == 8'hFF) && (a_i[6:0] == 7'd0);
    w_b_inf = (w_eb == 8'hFF) && (b_i[6:0] == 7'd0);

    // Order by magnitude so the difference is never negative.
    w_swap    = b_i[14:0] > a_i[14:0];
    w_sx      = w_swap ? w_sb : w_sa;
    w_sy      = w_swap ? w_sa : w_sb;
    w_ex      = w_swap ? w_eb : w_ea;
    w_ey      = w_swap ? w_ea : w_eb;
    w_mx      = w_swap ? w_mb : w_ma;
    w_my      = w_swap ? w_ma : w_mb;
    w_d       = w_ex - w_ey;
    w_eff_sub = w_sx ^ w_sy;

    // Hidden bit at [17], 10 guard bits below; shifted-out bits are jammed
    // into the LSB as a sticky bit.
    w_xa    = {1'b0, w_mx, 10'd0};
    w_yfull = {w_my, 26'd0} >> w_d;
    w_ya    = {1'b0, w_yfull[33:17], w_yfull[16] | (|w_yfull[15:0])};
    w_sum   = w_eff_sub ? (w_xa - w_ya) : (w_xa + w_ya);

    w_lz = 5'd0;
    for (int i = 0; i < 18; i++) begin
      if (w_sum[i]) w_lz = 5'(17 - i);
    end

    if (w_sum[18]) begin
      w_norm = {w_sum[18:2], w_sum[1] | w_sum[0]};
      w_exp  = {2'b00, w_ex} + 10'd1;
    end else begin
      w_norm = w_sum[17:0] << w_lz;
      w_exp  = {2'b00, w_ex} - {5'd0, w_lz};
    end

    w_rnd   = w_norm[9] & ((|w_norm[8:0]) | w_norm[10]);
    w_mr    = {1'b0, w_norm[17:10]} + {8'd0, w_rnd};
    // Rounding carry out of the mantissa bumps the exponent.
    w_exp_r = w_mr[8] ? (w_exp + 10'd1) : w_exp;
    w_frac  = w_mr[8] ? w_mr[7:1] : w_mr[6:0];

    if (w_a_nan || w_b_nan)                    res_o = C_QNAN;
    else if (w_a_inf && w_b_inf && (w_sa != w_sb)) res_o = C_QNAN;
    else if (w_a_inf)                          res_o = {w_sa, 8'hFF, 7'd0};
    else if (w_b_inf)                          res_o = {w_sb, 8'hFF, 7'd0};
    else if (w_sum == 19'd0)                   res_o = {w_sa & w_sb, 15'd0};
    else if (w_exp_r[9] || (w_exp_r == 10'd0)) res_o = {w_sx, 15'd0};
    else if (w_exp_r >= 10'd255)               res_o = {w_sx, 8'hFF, 7'd0};
    else                                       res_o = {w_sx, w_exp_r[7:0], w_frac};
  end
endmodule

module bf16_addsub_sched #(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic        req1_op,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_id,
  output logic        busy
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d, res_data_q, res_data_d;
  logic        op_q, op_d, id_q, id_d, last_grant_q, last_grant_d;
  logic        res_valid_q, res_valid_d, res_id_q, res_id_d;
  logic        grant_id, accept;
  logic [15:0] sum;

  bf16_addsub u_addsub (
    .a_i  (a_q),
    .b_i  (b_q),
    .op_i (op_q),
    .res_o(sum)
  );

  // Contention: round-robin against last_grant, or fixed req0 priority.
  // Otherwise whichever single requester is valid (0 when none).
  always_comb begin
    if (req0_valid && req1_valid) grant_id = RR_ENABLE ? ~last_grant_q : 1'b0;
    else                          grant_id = req1_valid;
  end

  // Gated by rst_n so no handshake is offered while reset is held.
  assign req0_ready = rst_n && (state_q == S_IDLE) && req0_valid && !grant_id;
  assign req1_ready = rst_n && (state_q == S_IDLE) && req1_valid &&  grant_id;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_id_d     = res_id_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d          = grant_id ? req1_a  : req0_a;
          b_d          = grant_id ? req1_b  : req0_b;
          op_d         = grant_id ? req1_op : req0_op;
          id_d         = grant_id;
          last_grant_d = grant_id;
          state_d      = S_CALC;
        end
      end
      S_CALC: begin
        res_data_d  = sum;
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      a_q          <= 16'd0;
      b_q          <= 16'd0;
      op_q         <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      res_valid_q  <= 1'b0;
      res_data_q   <= 16'd0;
      res_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_id_q     <= res_id_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = (state_q != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_bf16_addsub_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_bf16_addsub_sched
// Description : Self-checking bench. Drives one shared stimulus into a
//               round-robin and a fixed-priority instance; a transaction
//               model with real-number BF16 arithmetic predicts every output
//               each cycle, and directed tests pin literal results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bf16_addsub_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        v0, v1, op0, op1, res_ready;
  logic [15:0] a0, b0, a1, b1;
  logic        rdy0 [2];
  logic        rdy1 [2];
  logic        rvld [2];
  logic        rid  [2];
  logic        bsy  [2];
  logic [15:0] rdat [2];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  bf16_addsub_sched #(.RR_ENABLE(1'b1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(rdy0[0]), .req0_a(a0), .req0_b(b0), .req0_op(op0),
    .req1_valid(v1), .req1_ready(rdy1[0]), .req1_a(a1), .req1_b(b1), .req1_op(op1),
    .res_valid(rvld[0]), .res_ready(res_ready), .res_data(rdat[0]), .res_id(rid[0]),
    .busy(bsy[0])
  );

  bf16_addsub_sched #(.RR_ENABLE(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(rdy0[1]), .req0_a(a0), .req0_b(b0), .req0_op(op0),
    .req1_valid(v1), .req1_ready(rdy1[1]), .req1_a(a1), .req1_b(b1), .req1_op(op1),
    .res_valid(rvld[1]), .res_ready(res_ready), .res_data(rdat[1]), .res_id(rid[1]),
    .busy(bsy[1])
  );

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference arithmetic (real numbers) ----------------
  function automatic real bf16_to_real(input logic [15:0] x);
    real m;
    int  e;
    e = int'(x[14:7]);
    if (e == 0) return 0.0;
    m = (1.0 + real'(int'(x[6:0])) / 128.0) * (2.0 ** (e - 127));
    return x[15] ? -m : m;
  endfunction

  function automatic logic [15:0] real_to_bf16(input real r);
    real  m, fr, rem;
    int   e, ip;
    logic s;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    fr  = m * 128.0;
    ip  = int'($floor(fr));
    rem = fr - real'(ip);
    if (rem > 0.5 || (rem == 0.5 && (ip % 2) == 1)) ip++;
    if (ip == 256) begin ip = 128; e++; end
    return {s, 8'(e), 7'(ip - 128)};
  endfunction

  function automatic logic [15:0] bf16_ref(input logic [15:0] a, input logic [15:0] b, input logic op);
    real ra, rb;
    ra = bf16_to_real(a);
    rb = bf16_to_real(b);
    return real_to_bf16(op ? (ra - rb) : (ra + rb));
  endfunction

  // ---------------- transaction model, index 0 = RR, 1 = fixed ----------------
  bit          m_busy [2];
  bit          m_calc [2];
  bit          m_hold [2];
  bit          m_last [2];
  bit          m_pid  [2];
  bit          m_rid  [2];
  logic [15:0] m_pres [2];
  logic [15:0] m_res  [2];

  function automatic bit mdl_grant(input int k);
    if (v0 && v1) return (k == 0) ? !m_last[k] : 1'b0;
    return v1;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] = 0; m_calc[k] = 0; m_hold[k] = 0; m_last[k] = 1;
        m_pid[k] = 0; m_rid[k] = 0; m_pres[k] = 16'd0; m_res[k] = 16'd0;
      end
    end
    for (int k = 0; k < 2; k++) begin
      bit g, e0, e1;
      g  = mdl_grant(k);
      e0 = rst_n && !m_busy[k] && v0 && !g;
      e1 = rst_n && !m_busy[k] && v1 &&  g;
      chk($sformatf("k%0d_req0_ready", k), 16'(rdy0[k]), 16'(e0));
      chk($sformatf("k%0d_req1_ready", k), 16'(rdy1[k]), 16'(e1));
      chk($sformatf("k%0d_res_valid", k), 16'(rvld[k]), 16'(m_hold[k]));
      chk($sformatf("k%0d_res_data", k), rdat[k], m_res[k]);
      chk($sformatf("k%0d_res_id", k), 16'(rid[k]), 16'(m_rid[k]));
      chk($sformatf("k%0d_busy", k), 16'(bsy[k]), 16'(m_busy[k]));
      if (rst_n) begin
        if (!m_busy[k]) begin
          if (e0 || e1) begin
            m_busy[k] = 1; m_calc[k] = 1; m_pid[k] = g; m_last[k] = g;
            m_pres[k] = g ? bf16_ref(a1, b1, op1) : bf16_ref(a0, b0, op0);
          end
        end else if (m_calc[k]) begin
          m_calc[k] = 0; m_hold[k] = 1; m_res[k] = m_pres[k]; m_rid[k] = m_pid[k];
        end else if (res_ready) begin
          m_hold[k] = 0; m_busy[k] = 0;
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic finish_op(input bit id, input logic [15:0] exp, input string nm);
    bit got;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = id ? rdy1[0] : rdy0[0];
    end
    chk({nm, "_handshake"}, 16'(got), 16'd1);
    @(posedge clk); #1;
    if (id) v1 = 0; else v0 = 0;
    @(negedge clk);
    chk({nm, "_busy_t1"}, 16'(bsy[0]), 16'd1);
    chk({nm, "_valid_t1"}, 16'(rvld[0]), 16'd0);
    @(negedge clk);
    chk({nm, "_valid_t2"}, 16'(rvld[0]), 16'd1);
    chk({nm, "_data"}, rdat[0], exp);
    chk({nm, "_id"}, 16'(rid[0]), 16'(id));
  endtask

  task automatic run_op(input bit id, input logic [15:0] a, input logic [15:0] b,
                        input logic op, input logic [15:0] exp, input string nm);
    @(posedge clk); #1;
    if (id) begin a1 = a; b1 = b; op1 = op; v1 = 1; end
    else    begin a0 = a; b0 = b; op0 = op; v0 = 1; end
    finish_op(id, exp, nm);
  endtask

  int          g_rr [$];
  int          c_rr [$];
  logic [15:0] r_dat [$];
  logic        r_id  [$];
  int          n_fp0;
  bit          fp_r1;
  bit          got0;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; res_ready = 1;
    v0 = 1; a0 = 16'hC060; b0 = 16'h3FA0; op0 = 0;
    v1 = 1; a1 = 16'h40A0; b1 = 16'h4040; op1 = 1;

    // Model arithmetic pinned to hand-computed values.
    chk("ref_1p2", bf16_ref(16'h3F80, 16'h4000, 1'b0), 16'h4040);
    chk("ref_m3p5_1p25", bf16_ref(16'hC060, 16'h3FA0, 1'b0), 16'hC010);
    chk("ref_5m3", bf16_ref(16'h40A0, 16'h4040, 1'b1), 16'h4000);
    chk("ref_tie_up", bf16_ref(16'h3F81, 16'h3B80, 1'b0), 16'h3F82);

    // Reset held with both requesters valid.
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_k%0d_r0", k), 16'(rdy0[k]), 16'd0);
      chk($sformatf("rst_k%0d_r1", k), 16'(rdy1[k]), 16'd0);
      chk($sformatf("rst_k%0d_data", k), rdat[k], 16'd0);
    end
    @(posedge clk); #1 rst_n = 1;

    // Both valid for 12 cycles: RR alternates, fixed priority serves req0.
    n_fp0 = 0; fp_r1 = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rdy0[0] || rdy1[0]) begin g_rr.push_back(int'(rdy1[0])); c_rr.push_back(c); end
      if (rdy0[1]) n_fp0++;
      if (rdy1[1]) fp_r1 = 1;
      if (rvld[0]) begin r_dat.push_back(rdat[0]); r_id.push_back(rid[0]); end
    end
    chk("rr_grant_count", 16'(g_rr.size()), 16'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < g_rr.size()) begin
        chk($sformatf("rr_grant%0d_id", i), 16'(g_rr[i]), 16'(i % 2));
        chk($sformatf("rr_grant%0d_cycle", i), 16'(c_rr[i]), 16'(3 * i));
      end
    end
    chk("rr_result_count", 16'(r_dat.size()), 16'd4);
    if (r_dat.size() >= 2) begin
      chk("rr_res0_data", r_dat[0], 16'hC010);
      chk("rr_res0_id", 16'(r_id[0]), 16'd0);
      chk("rr_res1_data", r_dat[1], 16'h4000);
      chk("rr_res1_id", 16'(r_id[1]), 16'd1);
    end
    chk("fp_req0_grants", 16'(n_fp0), 16'd4);
    chk("fp_req1_never", 16'(fp_r1), 16'd0);
    @(posedge clk); #1 v0 = 0; v1 = 0;
    repeat (2) @(negedge clk);

    // Single requester, latency, rounding and cancellation.
    run_op(1'b0, 16'h3F80, 16'h4000, 1'b0, 16'h4040, "add_basic");
    run_op(1'b0, 16'h3F80, 16'h3B80, 1'b0, 16'h3F80, "rne_tie_even");
    run_op(1'b1, 16'h3F81, 16'h3B80, 1'b0, 16'h3F82, "rne_tie_up");
    run_op(1'b0, 16'h3F80, 16'h3F80, 1'b1, 16'h0000, "cancel");

    // Backpressure with req0 waiting.
    @(posedge clk); #1 res_ready = 0;
    run_op(1'b1, 16'h4020, 16'h3FC0, 1'b1, 16'h3F80, "bp");
    @(posedge clk); #1 v0 = 1; a0 = 16'h3F80; b0 = 16'h3F80; op0 = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", 16'(rvld[0]), 16'd1);
      chk("bp_hold_data", rdat[0], 16'h3F80);
      chk("bp_hold_id", 16'(rid[0]), 16'd1);
      chk("bp_no_ready", 16'(rdy0[0] | rdy1[0]), 16'd0);
    end
    @(posedge clk); #1 res_ready = 1;
    @(negedge clk);
    chk("bp_release_valid", 16'(rvld[0]), 16'd1);
    @(negedge clk);
    chk("bp_idle_busy", 16'(bsy[0]), 16'd0);
    chk("bp_idle_grant0", 16'(rdy0[0]), 16'd1);
    @(posedge clk); #1 v0 = 0;
    repeat (3) @(negedge clk);

    // Reset during CALC discards the operation.
    @(posedge clk); #1 v0 = 1; a0 = 16'h3F80; b0 = 16'h4000; op0 = 0;
    got0 = 0;
    for (int i = 0; i < 8 && !got0; i++) begin
      @(negedge clk);
      got0 = rdy0[0];
    end
    chk("mid_rst_handshake", 16'(got0), 16'd1);
    @(posedge clk); #1;
    v0 = 0; rst_n = 0;
    v1 = 1; a1 = 16'h40A0; b1 = 16'h4040; op1 = 1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("mid_rst_k%0d_valid", k), 16'(rvld[k]), 16'd0);
      chk($sformatf("mid_rst_k%0d_busy", k), 16'(bsy[k]), 16'd0);
      chk($sformatf("mid_rst_k%0d_data", k), rdat[k], 16'd0);
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1;
    finish_op(1'b1, 16'h4000, "post_reset");
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
